// File: rtl/mx_block_unpacker.sv
// MX block unpacker: turns a {ctrl, element} beat stream into per-element outputs tagged with the block exponent and index.
// Define MX_BLOCK_STATS_EN to build the saturating blk_count/err_count statistics counters.
module mx_block_unpacker #(
    parameter int ELEM_WIDTH = 6,
    parameter int EXP_WIDTH  = 8,
    parameter int BLOCK_SIZE = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ELEM_WIDTH+1:0]         in_data,
    input  logic [EXP_WIDTH-1:0]          in_exp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic [ELEM_WIDTH-2:0]         out_mantissa,
    output logic [EXP_WIDTH-1:0]          out_exp,
    output logic [$clog2(BLOCK_SIZE)-1:0] out_idx,
    output logic                          out_first,
    output logic                          out_last,
    output logic                          err_pulse,
    output logic [15:0]                   blk_count,
    output logic [15:0]                   err_count
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic {IDLE, IN_BLOCK} state_e;

    state_e                 state_q, state_d;
    logic [EXP_WIDTH-1:0]   exp_q, exp_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_sign_q, out_sign_d;
    logic [ELEM_WIDTH-2:0]  out_mant_q, out_mant_d;
    logic [EXP_WIDTH-1:0]   out_exp_q, out_exp_d;
    logic [IDX_W-1:0]       out_idx_q, out_idx_d;
    logic                   out_first_q, out_first_d;
    logic                   out_last_q, out_last_d;
    logic                   err_q, err_d;

    logic [1:0]       ctrl;
    logic             accept;
    logic [IDX_W-1:0] next_idx;
    logic             block_end;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign ctrl      = in_data[ELEM_WIDTH+1:ELEM_WIDTH];
    assign next_idx  = out_idx_q + IDX_W'(1);
    assign block_end = (ctrl == 2'b11) || (next_idx == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        out_valid_d = out_valid_q && !out_ready;
        out_sign_d  = out_sign_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_idx_d   = out_idx_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        if (accept) begin
            unique case (ctrl)
                2'b10: err_d = 1'b1;
                // A start inside a block flags the truncated block, then restarts.
                2'b01: begin
                    err_d       = (state_q == IN_BLOCK);
                    exp_d       = in_exp;
                    out_valid_d = 1'b1;
                    out_sign_d  = in_data[ELEM_WIDTH-1];
                    out_mant_d  = in_data[ELEM_WIDTH-2:0];
                    out_exp_d   = in_exp;
                    out_idx_d   = '0;
                    out_first_d = 1'b1;
                    out_last_d  = 1'b0;
                    state_d     = IN_BLOCK;
                end
                default: begin
                    if (state_q == IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_sign_d  = in_data[ELEM_WIDTH-1];
                        out_mant_d  = in_data[ELEM_WIDTH-2:0];
                        out_exp_d   = exp_q;
                        out_idx_d   = next_idx;
                        out_first_d = 1'b0;
                        out_last_d  = block_end;
                        if (block_end) state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_idx_q   <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_idx_q   <= out_idx_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sign     = out_sign_q;
    assign out_mantissa = out_mant_q;
    assign out_exp      = out_exp_q;
    assign out_idx      = out_idx_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign err_pulse    = err_q;

`ifdef MX_BLOCK_STATS_EN
    logic [15:0] blk_count_q, blk_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        blk_count_d = blk_count_q;
        err_count_d = err_count_q;
        if (out_valid_q && out_ready && out_last_q && (blk_count_q != '1))
            blk_count_d = blk_count_q + 16'd1;
        if (err_q && (err_count_q != '1))
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_q <= '0;
            err_count_q <= '0;
        end else begin
            blk_count_q <= blk_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign blk_count = blk_count_q;
    assign err_count = err_count_q;
`else
    assign blk_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mx_block_unpacker.sv
// Randomized self-checking bench for mx_block_unpacker against a queue-based block model.
module tb_mx_block_unpacker;

    localparam int EW = 6;
    localparam int XW = 8;
    localparam int BS = 32;
    localparam int IW = $clog2(BS);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EW+1:0] in_data;
    logic [XW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-2:0] out_mantissa;
    logic [XW-1:0] out_exp;
    logic [IW-1:0] out_idx;
    logic          out_first;
    logic          out_last;
    logic          err_pulse;
    logic [15:0]   blk_count;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    mx_block_unpacker #(.ELEM_WIDTH(EW), .EXP_WIDTH(XW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_mantissa(out_mantissa), .out_exp(out_exp), .out_idx(out_idx),
        .out_first(out_first), .out_last(out_last), .err_pulse(err_pulse),
        .blk_count(blk_count), .err_count(err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a block is a start element at index 0 followed by
    // elements at increasing indices until ctrl 11 or the BS-th element.
    logic [63:0]   exp_q[$];
    bit            m_in_blk;
    int            m_idx;
    logic [XW-1:0] m_exp;
    int            m_blks;
    int            m_errs;
    int            rdy_mode;
    bit            prev_stall;
    logic [63:0]   snap;

    function automatic logic [63:0] pack(input logic [EW-1:0] e, input logic [XW-1:0] x,
                                         input int idx, input bit f, input bit l);
        logic [IW-1:0] i;
        i = IW'(idx);
        return 64'({e, x, i, f, l});
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({out_sign, out_mantissa, out_exp, out_idx, out_first, out_last});
    endfunction

    task automatic model(input logic [1:0] c, input logic [EW-1:0] e, input logic [XW-1:0] x,
                         output bit err, output bit pushed);
        bit l;
        err = 0;
        pushed = 0;
        if (c == 2'b10) begin
            err = 1;
        end else if (c == 2'b01) begin
            err = m_in_blk;
            m_in_blk = 1;
            m_idx = 0;
            m_exp = x;
            exp_q.push_back(pack(e, x, 0, 1, 0));
            pushed = 1;
        end else if (!m_in_blk) begin
            err = 1;
        end else begin
            m_idx++;
            l = (c == 2'b11) || (m_idx == BS - 1);
            exp_q.push_back(pack(e, m_exp, m_idx, 0, l));
            pushed = 1;
            if (l) m_in_blk = 0;
        end
        if (err) m_errs++;
    endtask

    task automatic step(output bit acc);
        bit err, pushed;
        logic [63:0] e;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        #1;
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", dut_vec(), snap);
        end
        check("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_elem", dut_vec(), e);
                if (e[0]) m_blks++;
            end
        end
        prev_stall = out_valid && !out_ready;
        snap = dut_vec();
        acc = in_valid && in_ready;
        err = 0;
        pushed = 0;
        if (acc) model(in_data[EW+1:EW], in_data[EW-1:0], in_exp, err, pushed);
        @(posedge clk);
        #1;
        check("err_pulse", err_pulse, err);
        if (pushed) check("latency", out_valid, 1);
    endtask

    task automatic beat(input logic [1:0] c, input logic [EW-1:0] e, input logic [XW-1:0] x);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_data = {c, e};
        in_exp = x;
        for (int n = 0; n < 100; n++) begin
            step(acc);
            if (acc) break;
        end
        if (!acc) check("accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 300 && exp_q.size() > 0; n++) step(acc);
        check("drain_left", exp_q.size(), 0);
        idle(3);
    endtask

    task automatic check_stats();
`ifdef MX_BLOCK_STATS_EN
        check("blk_count", blk_count, m_blks);
        check("err_count", err_count, m_errs);
`else
        check("blk_count", blk_count, 0);
        check("err_count", err_count, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_pulse, 0);
        check("rst_fields", dut_vec(), 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_err_count", err_count, 0);
        rst = 1'b0;
        exp_q.delete();
        m_in_blk = 0;
        m_blks = 0;
        m_errs = 0;
        prev_stall = 0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
    endtask

    function automatic logic [EW-1:0] rnd_e();
        return EW'($urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int len;
        int r;
        in_valid = 1'b0;
        in_data = '0;
        in_exp = '0;
        out_ready = 1'b1;
        rdy_mode = 0;
        do_reset();

        // Full 32-element block terminated by ctrl 11.
        beat(2'b01, rnd_e(), 8'h7F);
        for (int i = 0; i < 30; i++) beat(2'b00, rnd_e(), XW'($urandom));
        beat(2'b11, rnd_e(), 8'h00);
        drain();

        // 33 beats without ctrl 11: idx 31 closes the block, 33rd beat is an error.
        beat(2'b01, rnd_e(), 8'h3C);
        for (int i = 0; i < 32; i++) beat(2'b00, rnd_e(), 8'h00);
        drain();

        // Short block interrupted by a new start.
        beat(2'b01, rnd_e(), 8'h10);
        for (int i = 0; i < 3; i++) beat(2'b00, rnd_e(), 8'h00);
        beat(2'b01, rnd_e(), 8'h20);
        beat(2'b11, rnd_e(), 8'h00);
        drain();

        // Downstream stall in the middle of a block.
        beat(2'b01, rnd_e(), 8'h55);
        beat(2'b00, rnd_e(), 8'h00);
        rdy_mode = 2;
        in_valid = 1'b1;
        in_data = {2'b00, 6'h2A};
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            check("stall_accept", acc, 0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        beat(2'b00, 6'h2A, 8'h00);
        beat(2'b11, rnd_e(), 8'h00);
        drain();
        check_stats();

        // Reserved ctrl inside a block, then reset mid-block.
        beat(2'b01, rnd_e(), 8'h66);
        beat(2'b00, rnd_e(), 8'h00);
        beat(2'b10, rnd_e(), 8'h00);
        beat(2'b00, rnd_e(), 8'h00);
        do_reset();
        rdy_mode = 0;
        idle(3);
        check("post_rst_empty", out_valid, 0);

        // Three good blocks and two protocol errors.
        for (int b = 0; b < 3; b++) begin
            len = $urandom_range(2, 5);
            beat(2'b01, rnd_e(), XW'($urandom));
            for (int i = 0; i < len - 2; i++) beat(2'b00, rnd_e(), 8'h00);
            beat(2'b11, rnd_e(), 8'h00);
            if (b == 0) beat(2'b10, rnd_e(), 8'h00);
            if (b == 1) beat(2'b00, rnd_e(), 8'h00);
        end
        drain();
        check_stats();

        // Randomized traffic with random backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 19);
            if (r == 19) begin
                idle(1);
            end else if (r == 0) begin
                beat(2'b10, rnd_e(), XW'($urandom));
            end else if (!m_in_blk) begin
                beat((r < 17) ? 2'b01 : 2'b00, rnd_e(), XW'($urandom));
            end else if (r < 3) begin
                beat(2'b11, rnd_e(), XW'($urandom));
            end else if (r == 3) begin
                beat(2'b01, rnd_e(), XW'($urandom));
            end else begin
                beat(2'b00, rnd_e(), XW'($urandom));
            end
        end
        rdy_mode = 0;
        drain();
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
